// File: rtl/spi_wb_pkg.sv
// Shared constants for the simple_spi Wishbone sequencer: register map, bit indices and FSM states.
package spi_wb_pkg;

    localparam logic [2:0] AdrSpcr = 3'd0;
    localparam logic [2:0] AdrSpsr = 3'd1;
    localparam logic [2:0] AdrSpdr = 3'd2;
    localparam logic [2:0] AdrSper = 3'd3;
    localparam logic [2:0] AdrSscr = 3'd4;

    localparam int unsigned SpcrSpe      = 6;
    localparam int unsigned SpcrMstr     = 4;
    localparam int unsigned SpcrCpol     = 3;
    localparam int unsigned SpcrCpha     = 2;
    localparam int unsigned SpsrRfempty  = 0;

    typedef logic [3:0] state_t;

    localparam state_t StIdle    = 4'd0;
    localparam state_t StSpcrOff = 4'd1;
    localparam state_t StSpcrOn  = 4'd2;
    localparam state_t StSper    = 4'd3;
    localparam state_t StSsOn    = 4'd4;
    localparam state_t StWaitTx  = 4'd5;
    localparam state_t StWrDr    = 4'd6;
    localparam state_t StPollSr  = 4'd7;
    localparam state_t StRdDr    = 4'd8;
    localparam state_t StSsOff   = 4'd9;

    function automatic logic [7:0] spcr_word(input logic cpol, input logic cpha,
                                             input logic [1:0] spr);
        logic [7:0] w;
        w = 8'h00;
        w[SpcrSpe]  = 1'b1;
        w[SpcrMstr] = 1'b1;
        w[SpcrCpol] = cpol;
        w[SpcrCpha] = cpha;
        w[1:0]      = spr;
        return w;
    endfunction

endpackage

// File: rtl/wb_single_access.sv
// Runs one classic Wishbone access per request; optional ack timeout via SPI_WB_MASTER_TIMEOUT_EN.
module wb_single_access #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req,
    input  logic       req_we,
    input  logic [2:0] req_adr,
    input  logic [7:0] req_dat,
    output logic       done,
    output logic [7:0] rdata,
    output logic       err,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    output logic       wb_we_o,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_ack_i
);

    logic       active_q;
    logic       we_q;
    logic [2:0] adr_q;
    logic [7:0] dat_q;

    // Acks outside an access never complete anything.
    assign done  = active_q & wb_ack_i;
    assign rdata = wb_dat_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= 3'd0;
            dat_q    <= 8'h00;
        end else if (active_q) begin
            if (done || err) begin
                active_q <= 1'b0;
            end
        end else if (req) begin
            active_q <= 1'b1;
            we_q     <= req_we;
            adr_q    <= req_adr;
            dat_q    <= req_dat;
        end
    end

`ifdef SPI_WB_MASTER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC) + 1;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (!active_q) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign err = active_q & ~wb_ack_i & (cnt_q == CntW'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYC;
    assign err = 1'b0;
`endif

    assign wb_cyc_o = active_q;
    assign wb_stb_o = active_q;
    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;

endmodule

// File: rtl/spi_wb_master.sv
// Byte-stream to simple_spi register sequencer. SPI_WB_MASTER_TIMEOUT_EN enables the ack timeout.
module spi_wb_master #(
    parameter int unsigned           SS_WIDTH    = 1,
    parameter logic [SS_WIDTH-1:0]   SS_SEL      = SS_WIDTH'(1),
    parameter int unsigned           TIMEOUT_CYC = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cfg_cpol,
    input  logic       cfg_cpha,
    input  logic [1:0] cfg_spr,
    input  logic [1:0] cfg_espr,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       err,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    output logic       wb_we_o,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_ack_i
);
    import spi_wb_pkg::*;

    state_t     state_q, state_d;
    logic       cpol_q, cpha_q;
    logic [1:0] spr_q, espr_q;
    logic [7:0] byte_q;
    logic       last_q;
    logic       rx_valid_q;
    logic [7:0] rx_data_q;
    logic       rdy_en_q;

    logic       acc_req, acc_we, acc_done, acc_err;
    logic [2:0] acc_adr;
    logic [7:0] acc_dat, acc_rdata, ss_word;
    logic       hs;

    always_comb begin
        ss_word = 8'h00;
        ss_word[SS_WIDTH-1:0] = SS_SEL;
    end

    // tx_ready stays low while reset is held and for the first cycle after.
    assign tx_ready = rdy_en_q & ((state_q == StIdle) | (state_q == StWaitTx));
    assign hs       = tx_valid & tx_ready;
    assign busy     = (state_q != StIdle);
    assign err      = acc_err;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

    always_comb begin
        acc_req = 1'b1;
        acc_we  = 1'b1;
        acc_adr = AdrSpcr;
        acc_dat = 8'h00;
        unique case (state_q)
            StSpcrOff: ;
            StSpcrOn:  acc_dat = spcr_word(cpol_q, cpha_q, spr_q);
            StSper:    begin acc_adr = AdrSper; acc_dat = {6'b000000, espr_q}; end
            StSsOn:    begin acc_adr = AdrSscr; acc_dat = ss_word; end
            StWrDr:    begin acc_adr = AdrSpdr; acc_dat = byte_q; end
            StPollSr:  begin acc_we = 1'b0; acc_adr = AdrSpsr; end
            StRdDr:    begin acc_we = 1'b0; acc_adr = AdrSpdr; end
            StSsOff:   acc_adr = AdrSscr;
            default:   acc_req = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (acc_err) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:    if (hs) state_d = StSpcrOff;
                StSpcrOff: if (acc_done) state_d = StSpcrOn;
                StSpcrOn:  if (acc_done) state_d = StSper;
                StSper:    if (acc_done) state_d = StSsOn;
                // The first byte was latched with the IDLE handshake, so go straight to SPDR.
                StSsOn:    if (acc_done) state_d = StWrDr;
                StWaitTx:  if (hs) state_d = StWrDr;
                StWrDr:    if (acc_done) state_d = StPollSr;
                StPollSr:  if (acc_done && !acc_rdata[SpsrRfempty]) state_d = StRdDr;
                StRdDr:    if (acc_done) state_d = last_q ? StSsOff : StWaitTx;
                StSsOff:   if (acc_done) state_d = StIdle;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            spr_q      <= 2'b00;
            espr_q     <= 2'b00;
            byte_q     <= 8'h00;
            last_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdy_en_q   <= 1'b1;
            rx_valid_q <= (state_q == StRdDr) && acc_done;
            if (hs) begin
                byte_q <= tx_data;
                last_q <= tx_last;
            end
            if (hs && (state_q == StIdle)) begin
                cpol_q <= cfg_cpol;
                cpha_q <= cfg_cpha;
                spr_q  <= cfg_spr;
                espr_q <= cfg_espr;
            end
            if ((state_q == StRdDr) && acc_done) begin
                rx_data_q <= acc_rdata;
            end
        end
    end

    wb_single_access #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_access (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req      (acc_req),
        .req_we   (acc_we),
        .req_adr  (acc_adr),
        .req_dat  (acc_dat),
        .done     (acc_done),
        .rdata    (acc_rdata),
        .err      (acc_err),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i)
    );

endmodule
